inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/inst_fifo.sv | 51 +++++
 rtl/inst_fetch.sv | 149 ++++++++++++++
 tb/tb_inst_fetch.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch types: datapath widths, reset PC default, FSM state encoding and buffer entry layout.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] data;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Generic synchronous FIFO, power-of-two DEPTH >= 2, head readable combinationally (zero-latency).
// Push into a full FIFO is accepted only together with a pop; clr empties it on the next edge.
module inst_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: in-order memory requests, zero-latency instruction buffer head, redirect flush.
// Requests gated by buffer credit and MAX_OUT; FETCH_MISALIGN_CHECK_EN enables the misaligned-redirect fault.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2,
    parameter int              MAX_OUT    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            memReqValid,
    input  logic            memReqReady,
    output logic [XLEN-1:0] memAddr,
    input  logic            memRspValid,
    input  logic [ILEN-1:0] memRspData,
    input  logic            redirectValid,
    input  logic [XLEN-1:0] redirectPc,
    output logic            instValid,
    input  logic            instReady,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] instPc,
    output logic            fetchFault
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_LIM = FIFO_DEPTH[CW:0];
    localparam logic [CW-1:0] MAX_LIM   = MAX_OUT[CW-1:0];

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   discard_cnt;

    logic [XLEN-1:0] redirect_pc;
    logic            misaligned;
    logic            req_xfer;
    logic            rsp_take;
    logic            rsp_live;
    logic [CW:0]     credit_used;

    fetch_entry_t    buf_wr;
    fetch_entry_t    buf_head;
    logic            buf_empty;
    logic            buf_full;
    logic [CW-1:0]   buf_count;

    logic [XLEN-1:0] aq_head;
    logic            aq_empty;
    logic            aq_full;
    logic [CW-1:0]   aq_count;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_pc = redirectPc;
    assign misaligned  = redirectValid && (redirectPc[1:0] != 2'b00);
    assign fetchFault  = (state == ST_FAULT);
    logic unused_sigs;
    assign unused_sigs = &{1'b0, buf_full, aq_empty, aq_full, aq_count};
`else
    assign redirect_pc = {redirectPc[XLEN-1:2], 2'b00};
    assign misaligned  = 1'b0;
    assign fetchFault  = 1'b0;
    logic unused_sigs;
    assign unused_sigs = &{1'b0, buf_full, aq_empty, aq_full, aq_count, redirectPc[1:0]};
`endif

    // Outstanding count includes requests already marked for discard, so MAX_OUT bounds real traffic.
    assign credit_used = {1'b0, buf_count} + {1'b0, outstanding};
    assign memReqValid = (state == ST_RUN) && (credit_used < DEPTH_LIM) && (outstanding < MAX_LIM);
    assign memAddr     = fetch_pc;
    assign req_xfer    = memReqValid && memReqReady;

    assign rsp_take = memRspValid && (outstanding != '0);
    assign rsp_live = rsp_take && (discard_cnt == '0);

    assign outstanding_nxt = outstanding + {{(CW-1){1'b0}}, req_xfer}
                                         - {{(CW-1){1'b0}}, rsp_take};

    assign buf_wr.pc   = aq_head;
    assign buf_wr.data = memRspData;

    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (redirectValid),
        .push      (rsp_live && !redirectValid),
        .push_data (buf_wr),
        .pop       (instReady && !redirectValid),
        .head      (buf_head),
        .empty     (buf_empty),
        .full      (buf_full),
        .count     (buf_count)
    );

    // Holds addresses of live (non-discarded) requests only; discarded ones are dropped on redirect.
    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .clr       (redirectValid),
        .push      (req_xfer && !redirectValid),
        .push_data (fetch_pc),
        .pop       (rsp_live),
        .head      (aq_head),
        .empty     (aq_empty),
        .full      (aq_full),
        .count     (aq_count)
    );

    assign instValid = !buf_empty;
    assign inst      = instValid ? buf_head.data : '0;
    assign instPc    = instValid ? buf_head.pc   : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = misaligned ? ST_FAULT : ST_RUN;
            ST_RUN:   if (misaligned) state_nxt = ST_FAULT;
            ST_FAULT: if (redirectValid && !misaligned) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            if (redirectValid) begin
                fetch_pc    <= redirect_pc;
                discard_cnt <= outstanding_nxt;
            end else begin
                if (req_xfer) fetch_pc <= next_pc(fetch_pc);
                if (rsp_take && (discard_cnt != '0)) discard_cnt <= discard_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: queue-based reference model compared every cycle plus directed literal checks.
module tb_inst_fetch;

    localparam int FD = 2;
    localparam int MO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReqValid;
    logic        memReqReady;
    logic [31:0] memAddr;
    logic        memRspValid;
    logic [31:0] memRspData;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        instValid;
    logic        instReady;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic        fetchFault;

    inst_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (FD),
        .MAX_OUT    (MO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .memReqValid   (memReqValid),
        .memReqReady   (memReqReady),
        .memAddr       (memAddr),
        .memRspValid   (memRspValid),
        .memRspData    (memRspData),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc),
        .instValid     (instValid),
        .instReady     (instReady),
        .inst          (inst),
        .instPc        (instPc),
        .fetchFault    (fetchFault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] d; } ent_t;
    typedef struct { logic [31:0] pc; bit drop; } infl_t;
    typedef struct { logic [31:0] d; int due; } mrsp_t;

    // reference model: buffer contents, in-flight requests, fetch PC, phase (0 idle, 1 run, 2 fault)
    ent_t        m_buf[$];
    infl_t       m_infl[$];
    logic [31:0] m_pc;
    int          m_state;

    mrsp_t       mem_q[$];
    logic [31:0] xfer_log[$];
    logic [31:0] dpc_log[$];
    logic [31:0] dinst_log[$];
    int          cyc = 0;
    int          lat = 1;
    bit          spur = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic        c_req_valid, c_inst_valid, c_fault;
    logic [31:0] c_addr, c_inst_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5EED_0000;
    endfunction

    function automatic bit m_req_valid();
        return (m_state == 1) && ((m_buf.size() + m_infl.size()) < FD) && (m_infl.size() < MO);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic clear_logs();
        xfer_log.delete();
        dpc_log.delete();
        dinst_log.delete();
    endtask

    // Entered at a negedge; applies reset for one rising edge and checks the reset outputs.
    task automatic do_reset();
        rst = 1'b1; memReqReady = 1'b0; instReady = 1'b0; redirectValid = 1'b0;
        redirectPc = '0; memRspValid = 1'b0; memRspData = '0; spur = 0;
        @(negedge clk); #1;
        chk("rst_memReqValid", memReqValid, 0);
        chk("rst_instValid", instValid, 0);
        chk("rst_fetchFault", fetchFault, 0);
        chk("rst_memAddr", memAddr, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_instPc", instPc, 32'h0);
        rst = 1'b0;
        m_buf.delete(); m_infl.delete(); m_pc = 32'h0; m_state = 0;
        mem_q.delete(); clear_logs();
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance model, wait for next negedge.
    task automatic cycle(input bit rdy, input bit irdy, input bit rv, input logic [31:0] rpc);
        infl_t       f;
        bit          xfer, mis;
        logic [31:0] tgt;
        memReqReady = rdy; instReady = irdy; redirectValid = rv; redirectPc = rpc;
        memRspValid = 1'b0; memRspData = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            memRspValid = 1'b1; memRspData = mem_q[0].d; void'(mem_q.pop_front());
        end else if (spur) begin
            memRspValid = 1'b1; memRspData = 32'hBAD0_BAD0;
        end
        #1;
        chk("memReqValid", memReqValid, m_req_valid());
        chk("memAddr", memAddr, m_pc);
        chk("instValid", instValid, m_buf.size() > 0);
        chk("inst", inst, (m_buf.size() > 0) ? m_buf[0].d : 32'h0);
        chk("instPc", instPc, (m_buf.size() > 0) ? m_buf[0].pc : 32'h0);
        chk("fetchFault", fetchFault, m_state == 2);
        c_req_valid = memReqValid; c_inst_valid = instValid; c_fault = fetchFault;
        c_addr = memAddr; c_inst_pc = instPc;
        if (instValid && instReady) begin dpc_log.push_back(instPc); dinst_log.push_back(inst); end
        if (memReqValid && memReqReady) begin
            mem_q.push_back('{d: mem_word(memAddr), due: cyc + lat});
            xfer_log.push_back(memAddr);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        mis = rv && (rpc[1:0] != 2'b00);
        tgt = rpc;
`else
        mis = 1'b0;
        tgt = {rpc[31:2], 2'b00};
`endif
        xfer = m_req_valid() && rdy;
        if (irdy && m_buf.size() > 0) void'(m_buf.pop_front());
        if (memRspValid && m_infl.size() > 0) begin
            f = m_infl.pop_front();
            if (!f.drop && !rv) m_buf.push_back('{pc: f.pc, d: memRspData});
        end
        if (rv) begin
            m_buf.delete();
            foreach (m_infl[i]) m_infl[i].drop = 1'b1;
            if (xfer) m_infl.push_back('{pc: m_pc, drop: 1'b1});
            m_pc = tgt;
        end else if (xfer) begin
            m_infl.push_back('{pc: m_pc, drop: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (m_state == 0)                m_state = mis ? 2 : 1;
        else if (m_state == 1 && mis)    m_state = 2;
        else if (m_state == 2 && rv && !mis) m_state = 1;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp4 [4];
        int n, cnt, idx;
        rst = 1'b1; memReqReady = 0; instReady = 0; redirectValid = 0; redirectPc = '0;
        memRspValid = 0; memRspData = '0;
        @(negedge clk);

        // streaming fetch, memory always ready, latency 1
        do_reset(); lat = 1;
        repeat (12) cycle(1, 1, 0, 0);
        exp4 = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++)
            chk("s1_req_addr", (i < xfer_log.size()) ? xfer_log[i] : 32'hxxxx_xxxx, exp4[i]);
        for (int i = 0; i < 3; i++) begin
            chk("s1_inst_pc", (i < dpc_log.size()) ? dpc_log[i] : 32'hxxxx_xxxx, exp4[i]);
            chk("s1_inst_data", (i < dinst_log.size()) ? dinst_log[i] : 32'hxxxx_xxxx, mem_word(exp4[i]));
        end

        // decode stalled: buffer fills, requests stop
        do_reset(); lat = 1;
        repeat (8) cycle(1, 0, 0, 0);
        chk("s2_req_count", xfer_log.size(), 2);
        chk("s2_req_valid", c_req_valid, 0);
        chk("s2_inst_valid", c_inst_valid, 1);
        chk("s2_inst_pc", c_inst_pc, 32'h0);

        // memory not ready for three cycles at 0x10
        do_reset(); lat = 1;
        for (n = 0; n < 30 && !(memReqValid && memAddr == 32'h10); n++) cycle(1, 1, 0, 0);
        chk("s3_reach_0x10", (memReqValid && memAddr == 32'h10), 1);
        repeat (3) begin
            cycle(0, 1, 0, 0);
            chk("s3_hold_addr", c_addr, 32'h10);
            chk("s3_hold_valid", c_req_valid, 1);
        end
        repeat (7) cycle(1, 1, 0, 0);
        cnt = 0; idx = -1;
        foreach (xfer_log[i]) if (xfer_log[i] == 32'h10) begin cnt++; idx = i; end
        chk("s3_single_xfer", cnt, 1);
        chk("s3_next_addr", (idx >= 0 && idx + 1 < xfer_log.size()) ? xfer_log[idx+1] : 32'hxxxx_xxxx, 32'h14);

        // redirect with two requests outstanding, latency 3
        do_reset(); lat = 3;
        for (n = 0; n < 20 && m_infl.size() != 2; n++) cycle(1, 1, 0, 0);
        chk("s4_two_outstanding", m_infl.size(), 2);
        cycle(1, 1, 1, 32'h100);
        clear_logs();
        repeat (20) cycle(1, 1, 0, 0);
        chk("s4_first_pc", (dpc_log.size() > 0) ? dpc_log[0] : 32'hxxxx_xxxx, 32'h100);
        chk("s4_first_inst", (dinst_log.size() > 0) ? dinst_log[0] : 32'hxxxx_xxxx, mem_word(32'h100));

        // redirect coinciding with pop and push
        do_reset(); lat = 1;
        for (n = 0; n < 20 && !(m_buf.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc); n++)
            cycle(1, 1, 0, 0);
        chk("s5_setup", (m_buf.size() > 0 && mem_q.size() > 0), 1);
        cycle(1, 1, 1, 32'h300);
        clear_logs();
        cycle(1, 1, 0, 0);
        chk("s5_buf_empty", c_inst_valid, 0);
        chk("s5_addr", c_addr, 32'h300);
        chk("s5_req_valid", c_req_valid, 1);
        repeat (8) cycle(1, 1, 0, 0);
        chk("s5_first_pc", (dpc_log.size() > 0) ? dpc_log[0] : 32'hxxxx_xxxx, 32'h300);

        // responses with nothing outstanding are ignored
        do_reset(); lat = 1;
        spur = 1;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        spur = 0;
        cycle(1, 0, 0, 0);
        chk("s6_no_spurious_push", c_inst_valid, 0);
        repeat (4) cycle(1, 1, 0, 0);
        chk("s6_first_inst", (dinst_log.size() > 0) ? dinst_log[0] : 32'hxxxx_xxxx, mem_word(32'h0));

        // fetch PC wraps at the top of the address space
        do_reset(); lat = 1;
        cycle(1, 1, 1, 32'hFFFF_FFF8);
        repeat (10) cycle(1, 1, 0, 0);
        exp4 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        for (int i = 0; i < 3; i++)
            chk("s7_wrap_addr", (i < xfer_log.size()) ? xfer_log[i] : 32'hxxxx_xxxx, exp4[i]);

        // misaligned redirect
        do_reset(); lat = 1;
        repeat (4) cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 32'h102);
        clear_logs();
`ifdef FETCH_MISALIGN_CHECK_EN
        repeat (5) cycle(1, 1, 0, 0);
        chk("s8_fault_set", c_fault, 1);
        chk("s8_no_requests", xfer_log.size(), 0);
        chk("s8_req_valid", c_req_valid, 0);
        cycle(1, 1, 1, 32'h200);
        clear_logs();
        repeat (8) cycle(1, 1, 0, 0);
        chk("s8_fault_clear", c_fault, 0);
        chk("s8_resume_addr", (xfer_log.size() > 0) ? xfer_log[0] : 32'hxxxx_xxxx, 32'h200);
        chk("s8_resume_pc", (dpc_log.size() > 0) ? dpc_log[0] : 32'hxxxx_xxxx, 32'h200);
`else
        repeat (8) cycle(1, 1, 0, 0);
        chk("s8_fault_low", c_fault, 0);
        chk("s8_aligned_addr", (xfer_log.size() > 0) ? xfer_log[0] : 32'hxxxx_xxxx, 32'h100);
        chk("s8_aligned_pc", (dpc_log.size() > 0) ? dpc_log[0] : 32'hxxxx_xxxx, 32'h100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
